divider_sequencer: RTL and testbench
====================================

# divider_sequencer

Control block for the approximate-divider-with-error-correction datapath. It accepts divide requests over a valid/ready handshake and holds the operands stable for the whole operation. It drives the one-hot step word that the normalizer, two's-complement, multiplier, accumulator, shifter and adder stages decode, in place of a free-running ring. It captures the uncorrected and corrected quotients (Q, Qc) on the final step and presents them on a valid/ready output with backpressure.

## Interface
- N, 8, operand width; the step word is N bits wide.
- TW, $clog2(N), width of the iteration-count field.
- T_MIN, 3, minimum final step index (at least one multiply iteration).

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_a  in  N  dividend
- in_b  in  N  divisor
- in_t  in  TW  requested final step index
- step  out  N  one-hot step word to the datapath
- op_a, op_b  out  N  latched operands, stable from accept to capture
- op_t  out  TW  effective (clamped) t
- eb_capture  out  1  high while step==1<<1; the datapath latches the divisor exponent
- dp_q, dp_qc  in  2N  datapath Q and Qc
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_q, out_qc  out  2N  captured results
- out_dz  out  1  divide-by-zero flag for the current result
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - step=0x01 (parking value).
- Accept:
  - Latch in_a/in_b into op_a/op_b.
  - t_eff = clamp(in_t, T_MIN, N-1).
  - If in_b==0: enter HOLD directly with out_q=all ones, out_qc=all ones, out_dz=1. The datapath is never stepped.
  - Otherwise enter RUN with step=1<<1.
- RUN: each cycle, step shifts left by one position: 1<<1 (normalize B, eb_capture=1), 1<<2 (normalize A), then 1<<3 … 1<<t_eff (iterations).
- Final step: on the clock edge that ends the cycle with step==1<<t_eff:
  - Register dp_q→out_q and dp_qc→out_qc, with out_dz=0.
  - Go to HOLD, with step returning to 0x01.
- HOLD:
  - out_valid=1.
  - out_q, out_qc and out_dz are stable until out_ready.
  - in_ready = out_ready, so a new request can be accepted in the same cycle the result is taken.
  - When both handshakes fire together, take the next state from the new request (RUN, or HOLD for dz).
  - When only the output handshake fires, go to IDLE.
- in_valid is ignored while in RUN; in_ready=0 there.
- No other sequencing input exists. Only reset aborts an operation.

## Timing
- Reset values:
  - state=IDLE, step=0x01.
  - in_ready=1 (combinational from state), out_valid=0, busy=0, eb_capture=0, out_dz=0.
  - out_q=0, out_qc=0, op_a=0, op_b=0.
  - op_t=T_MIN.
- Latency (accept edge at cycle 0):
  - step=1<<k during cycle k, for k=1..t_eff.
  - out_valid rises in cycle t_eff+1.
  - Divide-by-zero: out_valid in cycle 1.
- Throughput: one result every t_eff+1 cycles with out_ready held high, using the overlap in HOLD.
- The step word is registered, glitch-free and exactly one-hot at all times.
- eb_capture is decoded combinationally from the registered step.
- Reset asserted mid-RUN or mid-HOLD: the result is discarded and the block returns to reset values immediately (asynchronously). No out_valid is produced for the aborted request.
- Clamping:
  - in_t < T_MIN gives t_eff=T_MIN.
  - in_t > N-1 gives t_eff=N-1.
  - op_t reflects t_eff.

## Structure
- Package divider_pkg:
  - state enum {IDLE, RUN, HOLD}
  - T_MIN
  - DZ_RESULT (all-ones, 2N)
  - function clamp_t
- Sub-module step_ring:
  - N-bit one-hot shift register with synchronous load of 1<<1 and park to 0x01.
  - Outputs last = (step==1<<t_eff).
- The top level holds the FSM, operand and result registers, and the handshake logic.

## Test plan
- Reset, then in_a=0x60, in_b=0x30, in_t=5, out_ready=1 → step sequence 0x02,0x04,0x08,0x10,0x20 in cycles 1–5; out_valid in cycle 6; out_q/out_qc equal the dp_q/dp_qc values sampled in cycle 5.
- in_b=0 → out_valid in cycle 1, out_q=out_qc=0xFFFF, out_dz=1, step stays 0x01.
- in_t=1, then in_t=7 with N=8 → op_t=3 and 7; final step words 0x08 and 0x80.
- out_ready=0 for 4 cycles in HOLD → outputs stable, in_ready=0, in_valid ignored; out_ready=1 with in_valid=1 → both handshakes fire, next cycle step=0x02.
- Reset asserted during step=0x08 → step=0x01, out_valid=0, busy=0 immediately; no stale result after release.
- 20 back-to-back random requests with out_ready=1 → results in order, spaced t_eff+1 cycles apart, checked against the reference model.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the divider sequencer: operand width, step
// word constants, state encoding and the final-step clamp helper.
package divider_pkg;

    localparam int N  = 8;
    localparam int TW = $clog2(N);

    localparam logic [TW-1:0]  T_MIN      = TW'(32'd3);
    localparam logic [TW-1:0]  T_MAX      = TW'(N - 32'd1);
    localparam logic [2*N-1:0] DZ_RESULT  = {(2*N){1'b1}};
    localparam logic [N-1:0]   STEP_PARK  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]   STEP_FIRST = {{(N-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // At least one multiply iteration, never past the top bit of the step word.
    function automatic logic [TW-1:0] clamp_t(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        if (int'(t) < int'(T_MIN)) begin
            r = T_MIN;
        end else if (int'(t) > int'(T_MAX)) begin
            r = T_MAX;
        end else begin
            r = t;
        end
        return r;
    endfunction

endpackage

// File: rtl/step_ring.sv
// One-hot step word generator: loads the first datapath step, advances one
// position per cycle and parks back at bit 0 after the final step.
module step_ring
    import divider_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          park,
    input  logic          advance,
    input  logic [TW-1:0] t,
    output logic [N-1:0]  step,
    output logic          last
);

    logic [N-1:0] step_r;
    logic [N-1:0] step_next_s;

    // Next step word; running off the top parks instead of emptying the word.
    always_comb begin
        step_next_s = step_r;
        if (load) begin
            step_next_s = STEP_FIRST;
        end else if (park) begin
            step_next_s = STEP_PARK;
        end else if (advance) begin
            step_next_s = step_r[N-1] ? STEP_PARK : {step_r[N-2:0], 1'b0};
        end else begin
            step_next_s = step_r;
        end
    end

    // Step word register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_r <= STEP_PARK;
        end else begin
            step_r <= step_next_s;
        end
    end

    assign step = step_r;
    assign last = step_r[t];

endmodule

// File: rtl/divider_sequencer.sv
// Sequencer for the approximate divider datapath: request handshake, operand
// latching, one-hot step generation and result capture with backpressure.
module divider_sequencer
    import divider_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic [TW-1:0]  in_t,
    output logic [N-1:0]   step,
    output logic [N-1:0]   op_a,
    output logic [N-1:0]   op_b,
    output logic [TW-1:0]  op_t,
    output logic           eb_capture,
    input  logic [2*N-1:0] dp_q,
    input  logic [2*N-1:0] dp_qc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_q,
    output logic [2*N-1:0] out_qc,
    output logic           out_dz,
    output logic           busy
);

    state_t         state_r;
    state_t         state_next_s;
    logic           accept_s;
    logic           dz_req_s;
    logic           ring_load_s;
    logic           ring_park_s;
    logic           ring_adv_s;
    logic           ring_last_s;
    logic           capture_s;
    logic [N-1:0]   op_a_r;
    logic [N-1:0]   op_b_r;
    logic [TW-1:0]  op_t_r;
    logic [2*N-1:0] out_q_r;
    logic [2*N-1:0] out_qc_r;
    logic           out_dz_r;
    logic           out_valid_r;
    logic           busy_r;

    assign accept_s    = in_valid && in_ready;
    assign dz_req_s    = (in_b == {N{1'b0}});
    assign ring_load_s = accept_s && !dz_req_s;

    step_ring u_step_ring (
        .clk     (clk),
        .reset   (reset),
        .load    (ring_load_s),
        .park    (ring_park_s),
        .advance (ring_adv_s),
        .t       (op_t_r),
        .step    (step),
        .last    (ring_last_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; a divide-by-zero request skips straight to HOLD.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = dz_req_s ? HOLD : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (ring_last_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = RUN;
                end
            end
            HOLD: begin
                if (accept_s) begin
                    state_next_s = dz_req_s ? HOLD : RUN;
                end else if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs; in HOLD a new request rides on the result handshake.
    always_comb begin
        in_ready    = 1'b0;
        ring_park_s = 1'b0;
        ring_adv_s  = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: in_ready = 1'b1;
            RUN: begin
                if (ring_last_s) begin
                    ring_park_s = 1'b1;
                    capture_s   = 1'b1;
                end else begin
                    ring_adv_s  = 1'b1;
                end
            end
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Operand registers, held from accept until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a_r <= {N{1'b0}};
            op_b_r <= {N{1'b0}};
            op_t_r <= T_MIN;
        end else if (accept_s) begin
            op_a_r <= in_a;
            op_b_r <= in_b;
            op_t_r <= clamp_t(in_t);
        end
    end

    // Result registers: datapath quotients on the final step, saturated on zero divisor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q_r  <= {(2*N){1'b0}};
            out_qc_r <= {(2*N){1'b0}};
            out_dz_r <= 1'b0;
        end else if (capture_s) begin
            out_q_r  <= dp_q;
            out_qc_r <= dp_qc;
            out_dz_r <= 1'b0;
        end else if (accept_s && dz_req_s) begin
            out_q_r  <= DZ_RESULT;
            out_qc_r <= DZ_RESULT;
            out_dz_r <= 1'b1;
        end
    end

    // Status flags registered from the next state so they track state_r exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= (state_next_s == HOLD);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign op_a       = op_a_r;
    assign op_b       = op_b_r;
    assign op_t       = op_t_r;
    assign out_q      = out_q_r;
    assign out_qc     = out_qc_r;
    assign out_dz     = out_dz_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign eb_capture = step[1];

endmodule

// File: tb/tb_divider_sequencer.sv
// Scoreboard bench for divider_sequencer: the datapath quotients follow a cycle
// counter so each captured result pins down the exact capture cycle.
module tb_divider_sequencer;
    import divider_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   in_a = '0;
    logic [N-1:0]   in_b = '0;
    logic [TW-1:0]  in_t = '0;
    logic [N-1:0]   step;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [TW-1:0]  op_t;
    logic           eb_capture;
    logic [2*N-1:0] dp_q;
    logic [2*N-1:0] dp_qc;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*N-1:0] out_q;
    logic [2*N-1:0] out_qc;
    logic           out_dz;
    logic           busy;

    divider_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_t(in_t), .step(step),
        .op_a(op_a), .op_b(op_b), .op_t(op_t), .eb_capture(eb_capture),
        .dp_q(dp_q), .dp_qc(dp_qc), .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_qc(out_qc), .out_dz(out_dz), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign dp_q  = {cyc[7:0] ^ 8'hA5, cyc[7:0]};
    assign dp_qc = {cyc[7:0], ~cyc[7:0]};

    typedef struct {
        logic [15:0] q;
        logic [15:0] qc;
        logic        dz;
        int          vcyc;
    } sb_item_t;

    sb_item_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    // Directed back-to-back vectors: a, b, requested t, hand-clamped t_eff.
    localparam logic [7:0] TA [20] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA,
                                       8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    localparam logic [7:0] TB [20] = '{8'h03, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h0D, 8'h0F, 8'h10, 8'h12, 8'h00,
                                       8'h14, 8'h16, 8'h18, 8'h1A, 8'h1C, 8'h1E, 8'h20, 8'h22, 8'h24, 8'h26};
    localparam logic [2:0] TT [20] = '{3'd5, 3'd0, 3'd7, 3'd3, 3'd1, 3'd6, 3'd2, 3'd4, 3'd7, 3'd0,
                                       3'd5, 3'd3, 3'd6, 3'd1, 3'd2, 3'd4, 3'd7, 3'd5, 3'd3, 3'd6};
    localparam int         TE [20] = '{5, 3, 7, 3, 3, 6, 3, 4, 7, 3,
                                       5, 3, 6, 3, 3, 4, 7, 5, 3, 6};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a request, wait for acceptance, push the expected result.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] t,
                        input int te, output int c);
        sb_item_t e;
        logic [7:0] v;
        bit ok;
        in_a = a; in_b = b; in_t = t; in_valid = 1'b1;
        ok = 1'b0;
        c = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            check("accept_timeout", 32'(in_ready), 32'(1'b1));
        end else begin
            c = cyc;
            v = 8'(c + te);
            if (b == 8'h00) begin
                e.q = 16'hFFFF; e.qc = 16'hFFFF; e.dz = 1'b1; e.vcyc = c + 1;
            end else begin
                e.q = {v ^ 8'hA5, v}; e.qc = {v, ~v}; e.dz = 1'b0; e.vcyc = c + te + 1;
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    // Step sequence and clamped t, starting in the cycle after acceptance.
    task automatic watch(input int te, input logic [2:0] exp_t);
        for (int k = 1; k <= te; k++) begin
            @(negedge clk);
            check($sformatf("step_k%0d", k), 32'(step), 32'(8'(8'd1 << k)));
            check($sformatf("eb_k%0d", k), 32'(eb_capture), 32'(k == 1));
            if (k == 1) check("op_t", 32'(op_t), 32'(exp_t));
        end
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every output handshake.
    bit started = 1'b0;
    int rise = 0;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            started = 1'b0;
        end else if (out_valid) begin
            if (!started) begin
                started = 1'b1;
                rise = cyc;
            end
            if (out_ready) begin
                started = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    sb_item_t e;
                    e = sb.pop_front();
                    check("out_q", 32'(out_q), 32'(e.q));
                    check("out_qc", 32'(out_qc), 32'(e.qc));
                    check("out_dz", 32'(out_dz), 32'(e.dz));
                    check("valid_cycle", 32'(rise), 32'(e.vcyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [7:0] v;
        repeat (3) @(negedge clk);
        check("rst_step", 32'(step), 32'h01);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_t", 32'(op_t), 32'(T_MIN));
        reset = 1'b0;
        @(negedge clk);
        check("rst_eb", 32'(eb_capture), 32'd0);
        check("rst_out_dz", 32'(out_dz), 32'd0);
        check("rst_out_q", 32'(out_q), 32'd0);
        check("rst_out_qc", 32'(out_qc), 32'd0);
        check("rst_op_a", 32'(op_a), 32'd0);
        check("rst_op_b", 32'(op_b), 32'd0);
        @(posedge clk);
        #1;

        // Basic 0x60 / 0x30 with t=5.
        send(8'h60, 8'h30, 3'd5, 5, c);
        in_valid = 1'b0;
        watch(5, 3'd5);
        drain(20);

        // Divide by zero never steps the datapath.
        send(8'h10, 8'h00, 3'd5, 0, c);
        in_valid = 1'b0;
        @(negedge clk);
        check("dz_step", 32'(step), 32'h01);
        check("dz_busy", 32'(busy), 32'd1);
        check("dz_op_b", 32'(op_b), 32'd0);
        drain(20);

        // Clamping at both ends.
        send(8'h20, 8'h03, 3'd1, 3, c);
        in_valid = 1'b0;
        watch(3, 3'd3);
        drain(20);
        send(8'h20, 8'h03, 3'd7, 7, c);
        in_valid = 1'b0;
        watch(7, 3'd7);
        drain(20);

        // Backpressure: result held for 4 cycles, pending request ignored.
        out_ready = 1'b0;
        send(8'h40, 8'h08, 3'd4, 4, c);
        in_a = 8'h77; in_b = 8'h11; in_t = 3'd2; in_valid = 1'b1;
        v = 8'(c + 4);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_q", 32'(out_q), 32'({v ^ 8'hA5, v}));
            check("bp_op_a", 32'(op_a), 32'h40);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h77, 8'h11, 3'd2, 3, c);
        in_valid = 1'b0;
        @(negedge clk);
        check("overlap_step", 32'(step), 32'h02);
        drain(20);

        // Reset in the middle of a run discards the result.
        send(8'h60, 8'h30, 3'd5, 5, c);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_step", 32'(step), 32'h08);
        reset = 1'b1;
        #1;
        check("abort_step", 32'(step), 32'h01);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("no_stale_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back directed stream with out_ready held high.
        for (int i = 0; i < 20; i++) begin
            send(TA[i], TB[i], TT[i], TE[i], c);
        end
        in_valid = 1'b0;
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
